lcd_rx_monitor: RTL and testbench

- Receiver (device-side) end of the 4-bit HD44780 character-LCD bus that main drives on LCD_E/LCD_RS/LCD_RW/LCD_D.
- Samples the bus, reassembles bytes, executes the display-affecting command subset, and mirrors the 16x2 visible DDRAM onto two 128-bit row buses.
- Used in simulation and on-chip as a loopback checker, so benches compare row_a/row_b against main's intended text without a physical panel.

---
 rtl/lcd_rx_monitor.sv | 230 +++++++++++++++++++++++
 tb/tb_lcd_rx_monitor.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_rx_monitor.sv
// lcd_rx_monitor: device end of the 4-bit HD44780 bus, mirrors the 16x2 DDRAM.
// Define LCDRX_TIMING_CHK_EN to build the inter-byte gap checker.
module lcd_rx_monitor #(
   parameter int CLR_WAIT = 76000,
   parameter int CMD_WAIT = 2000
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         LCD_E,
   input  logic         LCD_RS,
   input  logic         LCD_RW,
   input  logic [3:0]   LCD_D,
   output logic [127:0] row_a,
   output logic [127:0] row_b,
   output logic         display_on,
   output logic         four_bit,
   output logic         byte_valid,
   output logic [7:0]   byte_out,
   output logic         byte_rs,
   output logic         timing_err
);
   typedef enum logic [1:0] {BOOT8, NIB_HI, NIB_LO} mode_e;

   logic [6:0]   sync1_q, sync2_q;
   logic         e_prev_q;
   logic         fall;
   logic         ev_q, ev_rs_q, ev_rw_q;
   logic [3:0]   ev_d_q;

   mode_e        mode_q, mode_d;
   logic [3:0]   hi_q, hi_d;
   logic [6:0]   addr_q, addr_d;
   logic         inc_q, inc_d;
   logic         disp_q, disp_d;
   logic         four_q, four_d;
   logic [127:0] row_a_q, row_a_d;
   logic [127:0] row_b_q, row_b_d;
   logic         bv_q, bv_d;
   logic [7:0]   bo_q, bo_d;
   logic         brs_q, brs_d;
   logic         have;
   logic [7:0]   byte_v;
   logic [6:0]   slot;

   // Fields travel with E so RS/RW/D come from the same synchronised sample
   always_ff @(posedge clk) begin
      if (!rst) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         e_prev_q <= 1'b0;
         ev_q     <= 1'b0;
         ev_rs_q  <= 1'b0;
         ev_rw_q  <= 1'b0;
         ev_d_q   <= '0;
      end else begin
         sync1_q  <= {LCD_E, LCD_RS, LCD_RW, LCD_D};
         sync2_q  <= sync1_q;
         e_prev_q <= sync2_q[6];
         ev_q     <= fall;
         ev_rs_q  <= sync2_q[5];
         ev_rw_q  <= sync2_q[4];
         ev_d_q   <= sync2_q[3:0];
      end
   end

   assign fall = ~sync2_q[6] & e_prev_q;

   function automatic logic [6:0] step_addr(input logic [6:0] a,
                                            input logic       up);
      logic [6:0] n;
      if (up)
         n = (a == 7'h27) ? 7'h40 : (a == 7'h67) ? 7'h00 : a + 7'd1;
      else
         n = (a == 7'h40) ? 7'h27 : (a == 7'h00) ? 7'h67 : a - 7'd1;
      return n;
   endfunction

   always_comb begin
      mode_d  = mode_q;
      hi_d    = hi_q;
      addr_d  = addr_q;
      inc_d   = inc_q;
      disp_d  = disp_q;
      four_d  = four_q;
      row_a_d = row_a_q;
      row_b_d = row_b_q;
      bv_d    = 1'b0;
      bo_d    = bo_q;
      brs_d   = brs_q;
      have    = 1'b0;
      byte_v  = '0;
      slot    = {~addr_q[3:0], 3'b000};
      if (ev_q) begin
         unique case (mode_q)
            BOOT8: begin
               if (!ev_rw_q) begin
                  have   = 1'b1;
                  byte_v = {ev_d_q, 4'h0};
                  if (!ev_rs_q && ev_d_q == 4'h2) begin
                     mode_d = NIB_HI;
                     four_d = 1'b1;
                  end
               end
            end
            NIB_HI: begin
               mode_d = NIB_LO;
               hi_d   = ev_d_q;
            end
            NIB_LO: begin
               mode_d = NIB_HI;
               if (!ev_rw_q) begin
                  have   = 1'b1;
                  byte_v = {hi_q, ev_d_q};
               end
            end
            default: mode_d = BOOT8;
         endcase
      end
      if (have) begin
         bv_d  = 1'b1;
         bo_d  = byte_v;
         brs_d = ev_rs_q;
         if (ev_rs_q) begin
            if (addr_q[6:4] == 3'b000) row_a_d[slot +: 8] = byte_v;
            if (addr_q[6:4] == 3'b100) row_b_d[slot +: 8] = byte_v;
            addr_d = step_addr(addr_q, inc_q);
         end else begin
            // Highest set bit selects the instruction
            priority case (1'b1)
               byte_v[7]: addr_d = byte_v[6:0];
               byte_v[6]: ;
               byte_v[5]: ;
               byte_v[4]: ;
               byte_v[3]: disp_d = byte_v[2];
               byte_v[2]: inc_d = byte_v[1];
               byte_v[1]: addr_d = 7'h00;
               byte_v[0]: begin
                  row_a_d = {16{8'h20}};
                  row_b_d = {16{8'h20}};
                  addr_d  = 7'h00;
                  inc_d   = 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         mode_q  <= BOOT8;
         hi_q    <= '0;
         addr_q  <= '0;
         inc_q   <= 1'b1;
         disp_q  <= 1'b0;
         four_q  <= 1'b0;
         row_a_q <= {16{8'h20}};
         row_b_q <= {16{8'h20}};
         bv_q    <= 1'b0;
         bo_q    <= '0;
         brs_q   <= 1'b0;
      end else begin
         mode_q  <= mode_d;
         hi_q    <= hi_d;
         addr_q  <= addr_d;
         inc_q   <= inc_d;
         disp_q  <= disp_d;
         four_q  <= four_d;
         row_a_q <= row_a_d;
         row_b_q <= row_b_d;
         bv_q    <= bv_d;
         bo_q    <= bo_d;
         brs_q   <= brs_d;
      end
   end

`ifdef LCDRX_TIMING_CHK_EN
   localparam int GW = $clog2(CLR_WAIT + 1);

   logic [GW-1:0] gap_q, gap_d;
   logic          seen_q, seen_d;
   logic          slow_q, slow_d;
   logic          terr_q, terr_d;
   int            need;

   // Gap saturates at the longest limit; anything beyond that is legal
   always_comb begin
      gap_d  = gap_q;
      seen_d = seen_q;
      slow_d = slow_q;
      terr_d = terr_q;
      need   = slow_q ? CLR_WAIT : CMD_WAIT;
      if (gap_q != GW'(CLR_WAIT)) gap_d = gap_q + 1'b1;
      if (have) begin
         if (seen_q && (int'(gap_q) + 1 < need)) terr_d = 1'b1;
         gap_d  = '0;
         seen_d = 1'b1;
         slow_d = (mode_q == BOOT8) || (!ev_rs_q && byte_v == 8'h01);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         gap_q  <= '0;
         seen_q <= 1'b0;
         slow_q <= 1'b0;
         terr_q <= 1'b0;
      end else begin
         gap_q  <= gap_d;
         seen_q <= seen_d;
         slow_q <= slow_d;
         terr_q <= terr_d;
      end
   end

   assign timing_err = terr_q;
`else
   logic [31:0] unused_cfg;
   assign unused_cfg = 32'(CLR_WAIT ^ CMD_WAIT);
   assign timing_err = 1'b0;
`endif

   assign row_a      = row_a_q;
   assign row_b      = row_b_q;
   assign display_on = disp_q;
   assign four_bit   = four_q;
   assign byte_valid = bv_q;
   assign byte_out   = bo_q;
   assign byte_rs    = brs_q;
endmodule

// File: tb/tb_lcd_rx_monitor.sv
// Bench for lcd_rx_monitor: vector table, corner sequences, random vs DDRAM model.
`timescale 1ns/1ps
module tb_lcd_rx_monitor;
   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         e = 1'b0, rs = 1'b0, rw = 1'b0;
   logic [3:0]   d = 4'h0;
   logic [127:0] row_a, row_b;
   logic         display_on, four_bit, byte_valid, byte_rs, timing_err;
   logic [7:0]   byte_out;

   int errors = 0;
   int checks = 0;
   int bv_cnt = 0;

   always #10 clk = ~clk;

   lcd_rx_monitor dut (
      .clk(clk), .rst(rst), .LCD_E(e), .LCD_RS(rs), .LCD_RW(rw), .LCD_D(d),
      .row_a(row_a), .row_b(row_b), .display_on(display_on),
      .four_bit(four_bit), .byte_valid(byte_valid), .byte_out(byte_out),
      .byte_rs(byte_rs), .timing_err(timing_err)
   );

   always @(posedge clk) if (byte_valid === 1'b1) bv_cnt++;

   // Model: DDRAM as a flat array, cursor walks an 80-cell ring of two 40-char lines
   logic [7:0] dd [128];
   int         m_addr;
   bit         m_inc, m_disp;

   task automatic m_clear();
      for (int i = 0; i < 128; i++) dd[i] = 8'h20;
      m_addr = 0;
      m_inc  = 1;
   endtask

   task automatic m_reset();
      m_clear();
      m_disp = 0;
   endtask

   task automatic m_step();
      int p;
      p = (m_addr >= 64) ? 40 + m_addr - 64 : m_addr;
      p = m_inc ? (p + 1) % 80 : (p + 79) % 80;
      m_addr = (p >= 40) ? 64 + p - 40 : p;
   endtask

   task automatic m_apply(input bit prs, input logic [7:0] b);
      if (prs) begin
         dd[m_addr] = b;
         m_step();
      end
      else if (b >= 8'h80) m_addr = int'(b) - 128;
      else if (b >= 8'h10) ;
      else if (b >= 8'h08) m_disp = b[2];
      else if (b >= 8'h04) m_inc = b[1];
      else if (b >= 8'h02) m_addr = 0;
      else if (b == 8'h01) m_clear();
   endtask

   function automatic logic [127:0] mrow(input int base);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) r[127-8*i -: 8] = dd[base+i];
      return r;
   endfunction

   function automatic logic [127:0] txt(input string s);
      logic [127:0] r;
      r = {16{8'h20}};
      for (int i = 0; i < s.len() && i < 16; i++) r[127-8*i -: 8] = s[i];
      return r;
   endfunction

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic pulse(input logic prs, input logic prw, input logic [3:0] pd);
      @(negedge clk);
      rs = prs; rw = prw; d = pd;
      @(negedge clk);
      e = 1'b1;
      repeat (3) @(negedge clk);
      e = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   task automatic wr(input logic prs, input logic [7:0] b);
      pulse(prs, 1'b0, b[7:4]);
      pulse(prs, 1'b0, b[3:0]);
      m_apply(prs, b);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      m_reset();
   endtask

   task automatic init_lcd();
      pulse(0, 0, 4'h3); pulse(0, 0, 4'h3); pulse(0, 0, 4'h3); pulse(0, 0, 4'h2);
      wr(0, 8'h28); wr(0, 8'h0C); wr(0, 8'h06); wr(0, 8'h01);
   endtask

   typedef struct {
      bit nib; bit rs; logic [7:0] b; string ea; string eb; bit disp; bit fb;
   } vec_t;

   function automatic vec_t mk(bit nib, bit prs, logic [7:0] b, string ea,
                               string eb, bit disp, bit fb);
      vec_t v;
      v.nib = nib; v.rs = prs; v.b = b; v.ea = ea; v.eb = eb;
      v.disp = disp; v.fb = fb;
      return v;
   endfunction

   vec_t tv [16];

   initial begin
      int bv0, nexp;
      logic [7:0] b;
      tv[0]  = mk(1, 0, 8'h30, "", "", 0, 0);
      tv[1]  = mk(1, 0, 8'h30, "", "", 0, 0);
      tv[2]  = mk(1, 0, 8'h30, "", "", 0, 0);
      tv[3]  = mk(1, 0, 8'h20, "", "", 0, 1);
      tv[4]  = mk(0, 0, 8'h28, "", "", 0, 1);
      tv[5]  = mk(0, 0, 8'h0C, "", "", 1, 1);
      tv[6]  = mk(0, 0, 8'h06, "", "", 1, 1);
      tv[7]  = mk(0, 0, 8'h01, "", "", 1, 1);
      tv[8]  = mk(0, 1, "H", "H", "", 1, 1);
      tv[9]  = mk(0, 1, "E", "HE", "", 1, 1);
      tv[10] = mk(0, 1, "L", "HEL", "", 1, 1);
      tv[11] = mk(0, 1, "L", "HELL", "", 1, 1);
      tv[12] = mk(0, 1, "O", "HELLO", "", 1, 1);
      tv[13] = mk(0, 0, 8'hC0, "HELLO", "", 1, 1);
      tv[14] = mk(0, 1, "A", "HELLO", "A", 1, 1);
      tv[15] = mk(0, 1, "B", "HELLO", "AB", 1, 1);
      m_reset();

      // Bus activity while reset is held must not disturb anything
      rst = 1'b0;
      pulse(0, 0, 4'h3);
      chk("rst row_a", row_a, {16{8'h20}});
      chk("rst row_b", row_b, {16{8'h20}});
      chk("rst display_on", display_on, 0);
      chk("rst four_bit", four_bit, 0);
      chk("rst byte_out", byte_out, 0);
      chk("rst byte_valid count", bv_cnt, 0);
      rst = 1'b1;

`ifdef LCDRX_TIMING_CHK_EN
      pulse(0, 0, 4'h2);
      repeat (76100) @(negedge clk);
      wr(1, "A");
      repeat (2500) @(negedge clk);
      wr(1, "B");
      chk("terr spaced", timing_err, 0);
      wr(0, 8'h01);
      repeat (1000) @(negedge clk);
      wr(1, "C");
      chk("terr short clear", timing_err, 1);
      chk("terr char kept", row_a[127:120], "C");
      do_reset();
      chk("terr reset", timing_err, 0);
`endif

      bv0 = bv_cnt;
      for (int i = 0; i < 16; i++) begin
         if (tv[i].nib) begin
            pulse(tv[i].rs, 0, tv[i].b[7:4]);
            m_apply(tv[i].rs, tv[i].b);
         end else begin
            wr(tv[i].rs, tv[i].b);
         end
         chk($sformatf("tv%0d row_a", i), row_a, txt(tv[i].ea));
         chk($sformatf("tv%0d row_b", i), row_b, txt(tv[i].eb));
         chk($sformatf("tv%0d display_on", i), display_on, tv[i].disp);
         chk($sformatf("tv%0d four_bit", i), four_bit, tv[i].fb);
         chk($sformatf("tv%0d byte_out", i), byte_out, tv[i].b);
         chk($sformatf("tv%0d byte_rs", i), byte_rs, tv[i].rs);
         if (i == 7) chk("init byte count", bv_cnt - bv0, 8);
      end
      chk("hello bytes", row_a[127:88], 40'h48454C4C4F);
      chk("ab bytes", row_b[127:112], 16'h4142);

      wr(0, 8'h8F); wr(1, "X"); wr(1, "Y");
      chk("edge X", row_a[7:0], 8'h58);
      chk("edge row_a", row_a, mrow(0));
      wr(0, 8'hC0); wr(1, "Z");
      chk("line2 start", row_b[127:120], "Z");

      wr(0, 8'h80); wr(0, 8'h04); wr(1, "Q");
      wr(0, 8'h06); wr(1, "R"); wr(1, "S");
      chk("dec wrap", row_a[127:120], "S");
      chk("dec wrap row_a", row_a, mrow(0));

      wr(0, 8'hA7); wr(1, "W"); wr(1, "V");
      chk("inc wrap", row_b[127:120], "V");

      wr(0, 8'h83); wr(1, "M");
      pulse(1, 1, 4'h4); pulse(1, 1, 4'hD);
      wr(1, "N");
      chk("read row_a", row_a, mrow(0));
      chk("read row_b", row_b, mrow(64));

      // Latency: byte_valid rises 3 clk after the edge that first sees E low
      pulse(1, 0, 4'h4);
      @(negedge clk);
      d = 4'hB;
      @(negedge clk);
      e = 1'b1;
      repeat (3) @(negedge clk);
      e = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         chk($sformatf("lat edge%0d", k), byte_valid, (k == 4));
      end
      chk("lat byte", byte_out, 8'h4B);
      m_apply(1, 8'h4B);
      chk("lat row_a", row_a, mrow(0));

      // Reset after a lone high nibble must restart in 8-bit boot mode
      pulse(1, 0, 4'h5);
      do_reset();
      chk("midrst row_a", row_a, {16{8'h20}});
      chk("midrst four_bit", four_bit, 0);
      init_lcd();
      wr(1, "P");
      chk("midrst realign", row_a, txt("P"));

      bv0  = bv_cnt;
      nexp = 0;
      for (int n = 0; n < 80; n++) begin
         int k;
         k = $urandom_range(0, 19);
         if (k < 10) begin
            wr(1, 8'($urandom_range(8'h21, 8'h7E)));
            nexp++;
         end else if (k < 13) begin
            b = 8'($urandom_range(0, 17));
            if ($urandom_range(0, 4) == 0) b = 8'($urandom_range(18, 39));
            if ($urandom_range(0, 1) == 1) b = b + 8'h40;
            wr(0, 8'h80 | b);
            nexp++;
         end else if (k == 13) begin
            wr(0, 8'(8'h04 | $urandom_range(0, 3)));
            nexp++;
         end else if (k == 14) begin
            wr(0, 8'(8'h08 | $urandom_range(0, 7)));
            nexp++;
         end else if (k == 15) begin
            wr(0, 8'(8'h02 | $urandom_range(0, 1)));
            nexp++;
         end else if (k == 16) begin
            wr(0, 8'($urandom_range(8'h10, 8'h7F)));
            nexp++;
         end else if (k == 17) begin
            wr(0, 8'h01);
            nexp++;
         end else begin
            pulse(1, 1, 4'($urandom));
            pulse(1, 1, 4'($urandom));
         end
         if (n % 8 == 7) begin
            chk($sformatf("rnd%0d row_a", n), row_a, mrow(0));
            chk($sformatf("rnd%0d row_b", n), row_b, mrow(64));
            chk($sformatf("rnd%0d display_on", n), display_on, m_disp);
         end
      end
      chk("rnd row_a", row_a, mrow(0));
      chk("rnd row_b", row_b, mrow(64));
      chk("rnd byte count", bv_cnt - bv0, nexp);
`ifndef LCDRX_TIMING_CHK_EN
      chk("timing_err tied", timing_err, 0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
